// File: rtl/ahb_arb_pkg.sv
// Shared encodings, FSM state type and helpers for the AHB arbiter.
// Pure definitions: no logic, no latency, no backpressure.
package ahb_arb_pkg;
  localparam int AHB_MAX_MASTERS = 16;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    ST_DEFAULT = 2'd0,
    ST_OWNED   = 2'd1,
    ST_LOCKED  = 2'd2
  } arb_state_t;

  function automatic logic [3:0] onehot_to_idx(input logic [AHB_MAX_MASTERS-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < AHB_MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter request/grant bundle; master side drives requests, slave side is the arbiter.
// Plain wires: no latency, no backpressure.
interface ahb_arbiter_if;
  import ahb_arb_pkg::*;

  logic [AHB_MAX_MASTERS-1:0] hbusreq;
  logic [AHB_MAX_MASTERS-1:0] hlock;
  logic                       hready;
  logic [1:0]                 htrans;
  logic [1:0]                 hresp;
  logic [AHB_MAX_MASTERS-1:0] hsplit;
  logic [AHB_MAX_MASTERS-1:0] hgrant;
  logic [3:0]                 hmaster;
  logic                       hmastlock;

  modport master (
    output hbusreq, hlock, hready, htrans, hresp, hsplit,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, hready, htrans, hresp, hsplit,
    output hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_rr_picker.sv
// Rotating-priority search: first set request at or above base, wrapping at N.
// Combinational, zero latency, no backpressure.
module ahb_rr_picker
  import ahb_arb_pkg::*;
#(
  parameter int N = AHB_MAX_MASTERS
) (
  input  logic [AHB_MAX_MASTERS-1:0] req,
  input  logic [3:0]                 base,
  output logic [AHB_MAX_MASTERS-1:0] win,
  output logic                       vld
);
  int idx;

  always_comb begin
    win = '0;
    vld = 1'b0;
    idx = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(base) + off;
      if (idx >= N) idx = idx - N;
      if (!vld && req[idx[3:0]]) begin
        win[idx[3:0]] = 1'b1;
        vld           = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter, round-robin with lock and tenure limit; grant registered one cycle after arbitration.
// hready=0 freezes grant/hmaster/hmastlock; split masking is built in with AHB_ARB_SPLIT_EN.
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 16,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 16
) (
  input logic          hclk,
  input logic          hrst,
  ahb_arbiter_if.slave bus
);
  localparam int TW = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
  localparam logic [TW-1:0] TEN_MAX = TW'(MAX_TENURE - 1);
  localparam logic [AHB_MAX_MASTERS-1:0] VALID =
    AHB_MAX_MASTERS'((17'd1 << NUM_MASTERS) - 17'd1);
  localparam logic [AHB_MAX_MASTERS-1:0] DEF_GRANT = AHB_MAX_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [3:0] DEF_IDX = 4'(DEFAULT_MASTER);

  arb_state_t                 state, state_nxt;
  logic [AHB_MAX_MASTERS-1:0] grant, grant_nxt;
  logic [3:0]                 owner, owner_nxt;
  logic [TW-1:0]              tenure, tenure_nxt;
  logic [3:0]                 hmaster_q;
  logic                       mastlock_q;
  logic                       arb_pt;

  logic [AHB_MAX_MASTERS-1:0] req_v, lock_v, cand, pick_win, split_mask;
  logic                       pick_vld, split_taken;
  logic [3:0]                 pick_idx, base;

  assign req_v    = bus.hbusreq & VALID;
  assign lock_v   = bus.hlock & VALID;
  assign cand     = req_v & ~split_mask;
  assign base     = (owner == 4'(NUM_MASTERS - 1)) ? 4'd0 : owner + 4'd1;
  assign pick_idx = onehot_to_idx(pick_win);

  ahb_rr_picker #(.N(NUM_MASTERS)) u_pick (
    .req  (cand),
    .base (base),
    .win  (pick_win),
    .vld  (pick_vld)
  );

`ifdef AHB_ARB_SPLIT_EN
  logic [AHB_MAX_MASTERS-1:0] split_set;

  // A split being issued wins over a release of the same master in one cycle.
  assign split_set   = (!bus.hready && bus.hresp == HRESP_SPLIT) ?
                       (AHB_MAX_MASTERS'(1) << hmaster_q) : '0;
  assign split_taken = bus.hready && (bus.hresp == HRESP_SPLIT);

  always_ff @(posedge hclk) begin
    if (hrst) split_mask <= '0;
    else      split_mask <= (split_mask & ~(bus.hsplit & VALID)) | split_set;
  end
`else
  logic unused_split;
  assign unused_split = ^{bus.hsplit, bus.hresp};
  assign split_mask   = '0;
  assign split_taken  = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state      <= ST_DEFAULT;
      grant      <= DEF_GRANT;
      owner      <= DEF_IDX;
      tenure     <= '0;
      hmaster_q  <= DEF_IDX;
      mastlock_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      owner  <= owner_nxt;
      tenure <= tenure_nxt;
      if (bus.hready) begin
        hmaster_q  <= owner;
        mastlock_q <= lock_v[owner];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    owner_nxt  = owner;
    tenure_nxt = tenure;
    arb_pt     = 1'b0;
    if (bus.hready) begin
      // Lock release forces a full re-arbitration in the same cycle.
      if (state == ST_LOCKED) arb_pt = !lock_v[owner];
      else arb_pt = (bus.htrans == HTRANS_IDLE) || !req_v[owner] ||
                    (tenure == TEN_MAX) || split_taken;
    end
    if (arb_pt) begin
      if (pick_vld) begin
        grant_nxt = pick_win;
        owner_nxt = pick_idx;
        state_nxt = lock_v[pick_idx] ? ST_LOCKED : ST_OWNED;
      end else begin
        grant_nxt = DEF_GRANT;
        owner_nxt = DEF_IDX;
        state_nxt = ST_DEFAULT;
      end
    end
    if (grant_nxt != grant) tenure_nxt = '0;
    else if (bus.hready && state == ST_OWNED && tenure != TEN_MAX) tenure_nxt = tenure + TW'(1);
  end

  assign bus.hgrant    = grant;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = mastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed and randomized bench for ahb_arbiter against a rule-level reference model.
`timescale 1ns/1ps
module tb_ahb_arbiter;
  import ahb_arb_pkg::*;

  localparam int NM = 16;
  localparam int DM = 0;
  localparam int MT = 16;
`ifdef AHB_ARB_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic hclk = 1'b0;
  logic hrst;
  ahb_arbiter_if bus();

  ahb_arbiter #(.NUM_MASTERS(NM), .DEFAULT_MASTER(DM), .MAX_TENURE(MT)) dut (
    .hclk (hclk),
    .hrst (hrst),
    .bus  (bus)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int passes = 0;
  bit model_on = 1'b0;

  int          m_owner, m_ten, m_hmaster;
  bit          m_locked, m_parked, m_mastlock;
  logic [15:0] m_mask;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_step();
    logic [15:0] req, lk, vm;
    bit arb, found, nlocked, nparked;
    int nxt, c;
    vm = '0;
    for (int i = 0; i < NM; i++) vm[i] = 1'b1;
    req = bus.hbusreq & vm;
    lk  = bus.hlock & vm;
    if (hrst) begin
      m_owner = DM; m_locked = 1'b0; m_parked = 1'b1; m_ten = 0;
      m_hmaster = DM; m_mastlock = 1'b0; m_mask = '0;
      return;
    end
    arb = 1'b0;
    if (bus.hready) begin
      if (m_locked) arb = !lk[m_owner[3:0]];
      else arb = (bus.htrans == 2'b00) || !req[m_owner[3:0]] || (m_ten == MT - 1) ||
                 (SPLIT_EN && bus.hresp == 2'b11);
    end
    nxt = m_owner; nlocked = m_locked; nparked = m_parked;
    if (arb) begin
      found = 1'b0;
      for (int k = 1; k <= NM; k++) begin
        c = (m_owner + k) % NM;
        if (!found && req[c[3:0]] && !m_mask[c[3:0]]) begin
          found = 1'b1;
          nxt = c;
        end
      end
      if (found) begin nlocked = lk[nxt[3:0]]; nparked = 1'b0; end
      else begin nxt = DM; nlocked = 1'b0; nparked = 1'b1; end
    end
    if (nxt != m_owner) m_ten = 0;
    else if (bus.hready && !m_locked && !m_parked && m_ten < MT - 1) m_ten++;
    if (SPLIT_EN) begin
      m_mask = m_mask & ~(bus.hsplit & vm);
      if (!bus.hready && bus.hresp == 2'b11) m_mask[m_hmaster[3:0]] = 1'b1;
    end
    if (bus.hready) begin
      m_hmaster  = m_owner;
      m_mastlock = lk[m_owner[3:0]];
    end
    m_owner = nxt; m_locked = nlocked; m_parked = nparked;
  endtask

  task automatic tick();
    model_step();
    @(posedge hclk);
    #1;
    if (model_on) begin
      check("model_hgrant", bus.hgrant, 16'd1 << m_owner[3:0]);
      check("model_hmaster", {12'd0, bus.hmaster}, 16'(m_hmaster));
      check("model_hmastlock", {15'd0, bus.hmastlock}, {15'd0, m_mastlock});
      check("grant_onehot", {15'd0, $onehot(bus.hgrant)}, 16'd1);
    end
  endtask

  initial begin
    int cnt;
    hrst = 1'b1;
    bus.hbusreq = '0; bus.hlock = '0; bus.hready = 1'b1;
    bus.htrans = HTRANS_IDLE; bus.hresp = HRESP_OKAY; bus.hsplit = '0;
    tick(); tick();
    hrst = 1'b0;
    model_on = 1'b1;
    check("rst_hgrant", bus.hgrant, 16'h0001);
    check("rst_hmaster", {12'd0, bus.hmaster}, 16'd0);
    check("rst_hmastlock", {15'd0, bus.hmastlock}, 16'd0);

    repeat (5) tick();
    check("park_hgrant", bus.hgrant, 16'h0001);
    check("park_hmaster", {12'd0, bus.hmaster}, 16'd0);
    check("park_hmastlock", {15'd0, bus.hmastlock}, 16'd0);

    // Owner 2, then handover to 5 on an IDLE transfer.
    bus.hbusreq = 16'h0004; tick();
    check("own2_hgrant", bus.hgrant, 16'h0004);
    bus.hbusreq = 16'h0024; bus.htrans = HTRANS_NONSEQ; tick();
    check("own2_hold", bus.hgrant, 16'h0004);
    bus.htrans = HTRANS_IDLE; tick();
    check("rr_hgrant5", bus.hgrant, 16'h0020);
    bus.htrans = HTRANS_NONSEQ; tick();
    check("rr_hmaster5", {12'd0, bus.hmaster}, 16'd5);

    // Locked owner 3 ignores competing requests until hlock drops.
    bus.hbusreq = 16'h0008; bus.hlock = 16'h0008; bus.htrans = HTRANS_IDLE; tick();
    check("lock_hgrant", bus.hgrant, 16'h0008);
    bus.hbusreq = 16'h00FF; bus.htrans = HTRANS_NONSEQ; tick();
    for (int i = 0; i < 40; i++) begin
      bus.hready = ($urandom_range(0, 3) != 0);
      bus.htrans = 2'($urandom);
      tick();
      check("lock_hold_hgrant", bus.hgrant, 16'h0008);
      check("lock_hmastlock", {15'd0, bus.hmastlock}, 16'd1);
    end
    bus.hlock = '0; bus.hready = 1'b1; bus.htrans = HTRANS_NONSEQ; tick();
    check("unlock_hgrant4", bus.hgrant, 16'h0010);

    // Tenure limit: master 1 keeps requesting, master 6 waits.
    bus.hbusreq = 16'h0002; bus.htrans = HTRANS_IDLE; tick();
    check("ten_hgrant1", bus.hgrant, 16'h0002);
    bus.hbusreq = 16'h0042; bus.htrans = HTRANS_NONSEQ;
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.hgrant != 16'h0002) break;
      cnt++;
    end
    check("ten_cycles", 16'(cnt), 16'(MT));
    check("ten_hgrant6", bus.hgrant, 16'h0040);

`ifdef AHB_ARB_SPLIT_EN
    bus.hbusreq = 16'h0010; bus.htrans = HTRANS_IDLE; tick();
    check("split_own4", bus.hgrant, 16'h0010);
    bus.htrans = HTRANS_NONSEQ; tick();
    bus.hready = 1'b0; bus.hresp = HRESP_SPLIT; tick();
    bus.hready = 1'b1; tick();
    bus.hresp = HRESP_OKAY; bus.htrans = HTRANS_IDLE;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("split_masked", bus.hgrant, 16'h0001);
    end
    bus.hsplit = 16'h0010; tick();
    bus.hsplit = '0; tick();
    check("split_release", bus.hgrant, 16'h0010);
`endif

    // Randomized traffic with sticky requests and rare resets.
    for (int n = 0; n < 3000; n++) begin
      hrst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) bus.hbusreq = 16'($urandom) & 16'($urandom);
      bus.hlock  = ($urandom_range(0, 3) == 0) ? (16'($urandom) & bus.hbusreq) : 16'h0000;
      bus.hready = ($urandom_range(0, 3) != 0);
      bus.htrans = ($urandom_range(0, 7) == 0) ? HTRANS_IDLE : {1'b1, 1'($urandom)};
      bus.hresp  = ($urandom_range(0, 5) == 0) ? HRESP_SPLIT : HRESP_OKAY;
      bus.hsplit = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
      tick();
    end
    hrst = 1'b0; bus.hresp = HRESP_OKAY; bus.hsplit = '0; bus.hready = 1'b1;
    bus.hbusreq = '0; bus.hlock = '0; bus.htrans = HTRANS_IDLE;
    repeat (3) tick();

    // Reset pulse while master 7 holds a lock.
    bus.hbusreq = 16'h0080; bus.hlock = 16'h0080; tick();
    check("lock7_hgrant", bus.hgrant, 16'h0080);
    bus.htrans = HTRANS_NONSEQ; tick();
    check("lock7_hmastlock", {15'd0, bus.hmastlock}, 16'd1);
    hrst = 1'b1; tick();
    hrst = 1'b0;
    check("midrst_hgrant", bus.hgrant, 16'h0001);
    check("midrst_hmastlock", {15'd0, bus.hmastlock}, 16'd0);
    check("midrst_hmaster", {12'd0, bus.hmaster}, 16'd0);
    bus.hbusreq = '0; bus.hlock = '0; bus.htrans = HTRANS_IDLE;
    repeat (2) tick();
    check("final_hgrant", bus.hgrant, 16'h0001);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
